wb_arbiter: RTL and testbench

Write-back arbiter for the dual-write-port register file. Collects register write requests from NREQ execution/memory sources over valid/ready handshakes, grants up to two per cycle in round-robin order, and drives the register file's two write ports from a registered write stage. Guarantees the two ports never target the same nonzero register in one cycle and never reorder writes from any single requester. Optionally exposes a forwarding lookup into the pending write stage.

---
 rtl/wb_arbiter.sv | 119 +++++++++++
 tb/tb_wb_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin grants up to two register writes per cycle into a registered write stage.
// Define WB_FWD_EN to enable the forwarding lookup into the pending write stage (otherwise fwd_hit_o/fwd_data_o are 0).
module wb_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [NREQ-1:0][4:0]   req_addr_i,
  input  logic [NREQ-1:0][31:0]  req_data_i,
  output logic [NREQ-1:0]        req_ready_o,
  output logic [1:0]             write_ena_o,
  output logic [1:0][4:0]        write_addr_o,
  output logic [1:0][31:0]       write_data_o,
  input  logic [1:0][4:0]        fwd_addr_i,
  output logic [1:0]             fwd_hit_o,
  output logic [1:0][31:0]       fwd_data_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [PW-1:0] idx_t;

  function automatic idx_t rr_idx(idx_t base, int off);
    return idx_t'((int'(base) + off) % NREQ);
  endfunction

  idx_t             ptr_q, ptr_d;
  idx_t             cand;
  idx_t             s0_idx, s1_idx;
  logic             s0_vld, s1_vld;
  logic [NREQ-1:0]  grant;
  logic [1:0]       ena_q;
  logic [1:0][4:0]  addr_q;
  logic [1:0][31:0] data_q;

  // Slot 1 skips requesters that would collide with slot 0 on a nonzero register.
  always_comb begin
    cand   = '0;
    s0_idx = '0;
    s1_idx = '0;
    s0_vld = 1'b0;
    s1_vld = 1'b0;
    grant  = '0;
    for (int p = 0; p < NREQ; p++) begin
      cand = rr_idx(ptr_q, p);
      if (req_valid_i[cand]) begin
        if (!s0_vld) begin
          s0_vld = 1'b1;
          s0_idx = cand;
        end else if (!s1_vld &&
                     ((req_addr_i[cand] != req_addr_i[s0_idx]) || (req_addr_i[cand] == 5'd0))) begin
          s1_vld = 1'b1;
          s1_idx = cand;
        end
      end
    end
    if (s0_vld) grant[s0_idx] = 1'b1;
    if (s1_vld) grant[s1_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (s1_vld)      ptr_d = rr_idx(s1_idx, 1);
    else if (s0_vld) ptr_d = rr_idx(s0_idx, 1);
  end

  assign req_ready_o = rst ? '0 : grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      ena_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (s0_vld) begin
        ena_q[0]  <= (req_addr_i[s0_idx] != 5'd0);
        addr_q[0] <= req_addr_i[s0_idx];
        data_q[0] <= req_data_i[s0_idx];
      end else begin
        ena_q[0] <= 1'b0;
      end
      if (s1_vld) begin
        ena_q[1]  <= (req_addr_i[s1_idx] != 5'd0);
        addr_q[1] <= req_addr_i[s1_idx];
        data_q[1] <= req_data_i[s1_idx];
      end else begin
        ena_q[1] <= 1'b0;
      end
    end
  end

  assign write_ena_o  = ena_q;
  assign write_addr_o = addr_q;
  assign write_data_o = data_q;

`ifdef WB_FWD_EN
  // Enabled slots never share a nonzero address, so at most one slot can match.
  always_comb begin
    fwd_hit_o  = '0;
    fwd_data_o = '0;
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 2; k++) begin
        if (ena_q[k] && (fwd_addr_i[j] != 5'd0) && (addr_q[k] == fwd_addr_i[j])) begin
          fwd_hit_o[j]  = 1'b1;
          fwd_data_o[j] = data_q[k];
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^fwd_addr_i;
  assign fwd_hit_o  = '0;
  assign fwd_data_o = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: grants checked on the spot, write-stage results via a scoreboard queue.
module tb_wb_arbiter;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req_valid = '0;
  logic [3:0][4:0]  req_addr  = '0;
  logic [3:0][31:0] req_data  = '0;
  logic [3:0]       req_ready;
  logic [1:0]       write_ena;
  logic [1:0][4:0]  write_addr;
  logic [1:0][31:0] write_data;
  logic [1:0][4:0]  fwd_addr  = '0;
  logic [1:0]       fwd_hit;
  logic [1:0][31:0] fwd_data;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string            tag;
    logic [1:0]       ena;
    logic [1:0][4:0]  addr;
    logic [1:0][31:0] data;
  } exp_t;

  exp_t sb[$];

  wb_arbiter #(.NREQ(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .write_ena_o  (write_ena),
    .write_addr_o (write_addr),
    .write_data_o (write_data),
    .fwd_addr_i   (fwd_addr),
    .fwd_hit_o    (fwd_hit),
    .fwd_data_o   (fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, check grants, queue the expected write stage, then compare it after the edge.
  task automatic step(input string tag, input logic [3:0] v, input logic [3:0][4:0] a,
                      input logic [3:0][31:0] d, input logic [3:0] er, input logic [1:0] ee,
                      input logic [4:0] ea0, input logic [4:0] ea1,
                      input logic [31:0] ed0, input logic [31:0] ed1);
    exp_t e;
    exp_t got;
    @(negedge clk);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    #1;
    chk({tag, " ready"}, 64'(req_ready), 64'(er));
    e.tag     = tag;
    e.ena     = ee;
    e.addr[0] = ea0;
    e.addr[1] = ea1;
    e.data[0] = ed0;
    e.data[1] = ed1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.tag, " ena"},   64'(write_ena),     64'(got.ena));
    chk({got.tag, " addr0"}, 64'(write_addr[0]), 64'(got.addr[0]));
    chk({got.tag, " addr1"}, 64'(write_addr[1]), 64'(got.addr[1]));
    chk({got.tag, " data0"}, 64'(write_data[0]), 64'(got.data[0]));
    chk({got.tag, " data1"}, 64'(write_data[1]), 64'(got.data[1]));
  endtask

  localparam logic [3:0][4:0]  A_ALL = {5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [3:0][31:0] D_ALL = {32'h104, 32'h103, 32'h102, 32'h101};

  initial begin
    // Reset held with everything requesting: nothing granted, stage cleared.
    step("rst0", 4'b1111, A_ALL, D_ALL, 4'b0000, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    step("rst1", 4'b1111, A_ALL, D_ALL, 4'b0000, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    rst = 1'b0;

    // Fairness: all four continuously valid with distinct targets alternate {0,1},{2,3}.
    step("rr0", 4'b1111, A_ALL, D_ALL, 4'b0011, 2'b11, 5'd1, 5'd2, 32'h101, 32'h102);
    step("rr1", 4'b1111, A_ALL, D_ALL, 4'b1100, 2'b11, 5'd3, 5'd4, 32'h103, 32'h104);
    step("rr2", 4'b1111, A_ALL, D_ALL, 4'b0011, 2'b11, 5'd1, 5'd2, 32'h101, 32'h102);
    step("rr3", 4'b1111, A_ALL, D_ALL, 4'b1100, 2'b11, 5'd3, 5'd4, 32'h103, 32'h104);

    // Two distinct requesters, ptr 0 -> ptr 3.
    step("dist", 4'b0101, {5'd0, 5'd7, 5'd0, 5'd5}, {32'h0, 32'h22, 32'h0, 32'h11},
         4'b0101, 2'b11, 5'd5, 5'd7, 32'h11, 32'h22);
    // Only req3 from ptr 3: slot 1 unused and holds, ptr wraps to 0.
    step("wrap", 4'b1000, {5'd8, 5'd0, 5'd0, 5'd0}, {32'h33, 32'h0, 32'h0, 32'h0},
         4'b1000, 2'b01, 5'd8, 5'd7, 32'h33, 32'h22);

    // Same nonzero address: req1 wins, req3 follows next cycle so r9 ends with 0xB.
    step("same0", 4'b1010, {5'd9, 5'd0, 5'd9, 5'd0}, {32'hB, 32'h0, 32'hA, 32'h0},
         4'b0010, 2'b01, 5'd9, 5'd7, 32'hA, 32'h22);
    step("same1", 4'b1000, {5'd9, 5'd0, 5'd0, 5'd0}, {32'hB, 32'h0, 32'h0, 32'h0},
         4'b1000, 2'b01, 5'd9, 5'd7, 32'hB, 32'h22);

    // Writes to r0 consume a slot but never enable the port.
    step("r0", 4'b0011, {5'd0, 5'd0, 5'd4, 5'd0}, {32'h0, 32'h0, 32'h4, 32'hFF},
         4'b0011, 2'b10, 5'd0, 5'd4, 32'hFF, 32'h4);
    // Two r0 writes are not an address conflict.
    step("r0pair", 4'b1100, {5'd0, 5'd0, 5'd0, 5'd0}, {32'hEE, 32'hDD, 32'h0, 32'h0},
         4'b1100, 2'b00, 5'd0, 5'd0, 32'hDD, 32'hEE);

    // Load r6=0x66 into slot 1 for the forwarding lookup.
    step("fwdld", 4'b1001, {5'd6, 5'd0, 5'd0, 5'd3}, {32'h66, 32'h0, 32'h0, 32'h30},
         4'b1001, 2'b11, 5'd3, 5'd6, 32'h30, 32'h66);
    fwd_addr = {5'd0, 5'd6};
    #1;
`ifdef WB_FWD_EN
    chk("fwd hit 6,0",  64'(fwd_hit),     64'(2'b01));
    chk("fwd data0 6",  64'(fwd_data[0]), 64'h66);
    fwd_addr = {5'd3, 5'd6};
    #1;
    chk("fwd hit 6,3",  64'(fwd_hit),     64'(2'b11));
    chk("fwd data1 3",  64'(fwd_data[1]), 64'h30);
`else
    chk("fwd hit off",  64'(fwd_hit),     64'(2'b00));
    chk("fwd data off", 64'(fwd_data),    64'h0);
`endif

    // Idle cycle: no grants, both ports disabled, addr/data hold; forwarding misses.
    step("idle", 4'b0000, {5'd6, 5'd0, 5'd0, 5'd3}, '0, 4'b0000, 2'b00, 5'd3, 5'd6, 32'h30, 32'h66);
    #1;
    chk("fwd idle miss", 64'(fwd_hit), 64'(2'b00));
    fwd_addr = '0;

    // Reset mid-operation discards the request and clears the stage.
    rst = 1'b1;
    step("rstmid", 4'b0001, {5'd0, 5'd0, 5'd0, 5'd10}, {32'h0, 32'h0, 32'h0, 32'hAA},
         4'b0000, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    rst = 1'b0;
    step("post", 4'b0001, {5'd0, 5'd0, 5'd0, 5'd10}, {32'h0, 32'h0, 32'h0, 32'hAA},
         4'b0001, 2'b01, 5'd10, 5'd0, 32'hAA, 32'h0);
    // Pointer advanced to 1 after granting req0: req0 and req1 both valid -> req1 in slot 0 order.
    step("ptr1", 4'b1011, {5'd12, 5'd0, 5'd11, 5'd10}, {32'hC, 32'h0, 32'hB, 32'hA},
         4'b1010, 2'b11, 5'd11, 5'd12, 32'hB, 32'hC);

    chk("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
